// File: rtl/multicycle_main_control.sv
// Main control FSM for the 32-bit multicycle processor: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and write strobe.
module multicycle_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e state_q;
    state_e state_d;

    logic       iorD_raw;
    logic       memWrite_raw;
    logic       irWrite_raw;
    logic       regDst_raw;
    logic       memtoReg_raw;
    logic       regWrite_raw;
    logic       aluSrcA_raw;
    logic [1:0] aluSrcB_raw;
    logic [1:0] aluOp_raw;
    logic [1:0] pcSrc_raw;
    logic       pcWrite_raw;
    logic       branch_raw;
    logic       illegal_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused encodings 12-15 fall into the default arm and recover to FETCH.
    always_comb begin
        state_d     = state_q;
        illegal_raw = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        state_d     = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (Op == OP_SW)      state_d = MEMWR;
                else if (Op == OP_LW) state_d = MEMRD;
                else                  state_d = FETCH;
            end
            MEMRD: begin
                if (mem_ready) state_d = MEMWB;
            end
            MEMWR: begin
                if (mem_ready) state_d = FETCH;
            end
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        iorD_raw     = 1'b0;
        memWrite_raw = 1'b0;
        irWrite_raw  = 1'b0;
        regDst_raw   = 1'b0;
        memtoReg_raw = 1'b0;
        regWrite_raw = 1'b0;
        aluSrcA_raw  = 1'b0;
        aluSrcB_raw  = 2'b00;
        aluOp_raw    = 2'b00;
        pcSrc_raw    = 2'b00;
        pcWrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        case (state_q)
            FETCH: begin
                aluSrcB_raw = 2'b01;
                irWrite_raw = mem_ready;
                pcWrite_raw = mem_ready;
            end
            DECODE: begin
                aluSrcB_raw = 2'b11;
            end
            MEMADR, ADDIEX: begin
                aluSrcA_raw = 1'b1;
                aluSrcB_raw = 2'b10;
            end
            MEMRD: begin
                iorD_raw = 1'b1;
            end
            MEMWR: begin
                iorD_raw     = 1'b1;
                memWrite_raw = 1'b1;
            end
            MEMWB: begin
                memtoReg_raw = 1'b1;
                regWrite_raw = 1'b1;
            end
            RTYPEEX: begin
                aluSrcA_raw = 1'b1;
                aluOp_raw   = 2'b10;
            end
            RTYPEWB: begin
                regDst_raw   = 1'b1;
                regWrite_raw = 1'b1;
            end
            BEQEX: begin
                aluSrcA_raw = 1'b1;
                aluOp_raw   = 2'b01;
                pcSrc_raw   = 2'b01;
                branch_raw  = 1'b1;
            end
            ADDIWB: begin
                regWrite_raw = 1'b1;
            end
            JEX: begin
                pcSrc_raw   = 2'b10;
                pcWrite_raw = 1'b1;
            end
            default: begin
                iorD_raw = 1'b0;
            end
        endcase
    end

    // During reset every strobe is killed and the selects present their FETCH values.
    always_comb begin
        IorD       = iorD_raw;
        MemWrite   = memWrite_raw;
        IRWrite    = irWrite_raw;
        RegDst     = regDst_raw;
        MemtoReg   = memtoReg_raw;
        RegWrite   = regWrite_raw;
        ALUSrcA    = aluSrcA_raw;
        ALUSrcB    = aluSrcB_raw;
        ALUOp      = aluOp_raw;
        PCSrc      = pcSrc_raw;
        PCWrite    = pcWrite_raw;
        Branch     = branch_raw;
        illegal_op = illegal_raw;
        if (!rst_n) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b01;
            ALUOp      = 2'b00;
            PCSrc      = 2'b00;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            illegal_op = 1'b0;
        end
        PCEn = PCWrite | (Branch & Zero);
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized scoreboard bench: instructions are expanded into their phase lists,
// expected control words are queued per cycle and a monitor compares them.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, Branch, PCEn, illegal_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .Branch(Branch), .PCEn(PCEn), .illegal_op(illegal_op), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
        logic [1:0] aluSrcB, aluOp, pcSrc;
        logic       pcWrite, branch, pcEn, illegalOp;
    } ctrl_t;

    ctrl_t actual;
    assign actual = {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                     ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, PCEn, illegal_op};

    ctrl_t expQ[$];
    int    cycQ[$];
    int    total = 0;
    int    bad = 0;
    int    pushed = 0;
    int    popped = 0;

    int         plan[$];
    logic [5:0] curOp;
    bit         curLegal;

    // Expected control word for one cycle of a given instruction phase.
    function automatic ctrl_t modelOut(input int ph, input bit r, input bit m, input bit z,
                                       input bit legal);
        ctrl_t e;
        e = '0;
        e.st = ph[3:0];
        if (!r) begin
            e.aluSrcB = 2'b01;
            return e;
        end
        case (ph)
            0:  begin e.aluSrcB = 2'b01; e.irWrite = m; e.pcWrite = m; end
            1:  begin e.aluSrcB = 2'b11; e.illegalOp = !legal; end
            2, 9: begin e.aluSrcA = 1; e.aluSrcB = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.memtoReg = 1; e.regWrite = 1; end
            5:  begin e.iord = 1; e.memWrite = 1; end
            6:  begin e.aluSrcA = 1; e.aluOp = 2'b10; end
            7:  begin e.regDst = 1; e.regWrite = 1; end
            8:  begin e.aluSrcA = 1; e.aluOp = 2'b01; e.pcSrc = 2'b01; e.branch = 1; end
            10: e.regWrite = 1;
            11: begin e.pcSrc = 2'b10; e.pcWrite = 1; end
            default: e = '0;
        endcase
        e.pcEn = e.pcWrite | (e.branch & z);
        return e;
    endfunction

    // Choose the instruction for slot idx (a fixed opening sequence, then random)
    // and expand it into the list of phases it must visit.
    task automatic startInstr(input int idx);
        logic [5:0] directed [8];
        logic [5:0] illegals [3];
        logic [5:0] legals [6];
        int k;
        directed = '{6'b100011, 6'b000000, 6'b000100, 6'b000100,
                     6'b101011, 6'b111111, 6'b001000, 6'b000010};
        illegals = '{6'b111111, 6'b000011, 6'b100000};
        legals   = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        if (idx < 8) begin
            curOp = directed[idx];
        end else begin
            k = $urandom_range(0, 6);
            if (k == 6) curOp = illegals[$urandom_range(0, 2)];
            else        curOp = legals[k];
        end
        curLegal = 1'b1;
        case (curOp)
            6'b100011: plan = '{0, 1, 2, 3, 4};
            6'b101011: plan = '{0, 1, 2, 5};
            6'b000000: plan = '{0, 1, 6, 7};
            6'b000100: plan = '{0, 1, 8};
            6'b001000: plan = '{0, 1, 9, 10};
            6'b000010: plan = '{0, 1, 11};
            default: begin plan = '{0, 1}; curLegal = 1'b0; end
        endcase
    endtask

    task automatic applyStimulus(input bit r, input bit m, input bit z);
        rst_n     = r;
        mem_ready = m;
        Zero      = z;
        Op        = curOp;
    endtask

    task automatic checkOutput(input ctrl_t exp, input int cyc);
        total++;
        if (actual !== exp) begin
            bad++;
            $display("[TB] FAIL ctrl cycle=%0d got=%h want=%h (state got=%0d want=%0d)",
                     cyc, actual, exp, actual.st, exp.st);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            ctrl_t e;
            int c;
            e = expQ.pop_front();
            c = cycQ.pop_front();
            popped++;
            checkOutput(e, c);
        end
    end

    initial begin
        int ph;
        int instrIdx;
        bit r, m, z;
        rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0; Op = 6'd0; curOp = 6'd0;
        @(posedge clk);
        #1;
        instrIdx = 0;
        startInstr(instrIdx);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = (cyc < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
            m = (cyc < 2) ? 1'b1 : ($urandom_range(0, 99) < 70);
            z = $urandom_range(0, 1);
            applyStimulus(r, m, z);
            ph = plan[0];
            expQ.push_back(modelOut(ph, r, m, z, curLegal));
            cycQ.push_back(cyc);
            pushed++;
            @(posedge clk);
            #1;
            if (!r) begin
                startInstr(instrIdx);
            end else if (!((ph == 0 || ph == 3 || ph == 5) && !m)) begin
                void'(plan.pop_front());
                if (plan.size() == 0) begin
                    instrIdx++;
                    startInstr(instrIdx);
                end
            end
        end
        repeat (2) @(posedge clk);
        total++;
        if (popped != pushed) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=%0d", popped, pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control state machine for the 32-bit multicycle processor. It takes the opcode from the instruction register plus the ALU zero flag and the memory ready handshake. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath mux select and write strobe, and supplies the 2-bit ALUOp consumed by the downstream ALU control decoder (00 = add, 01 = subtract, 1x = decode by funct).

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  synchronous, active-low reset
- Op  input  6  opcode field, instruction bits [31:26], from the instruction register
- Zero  input  1  ALU zero flag, valid in the branch-execute cycle
- mem_ready  input  1  memory has completed the current read or write this cycle
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select: 0 = rt, 1 = rd
- MemtoReg  output  1  writeback data select: 0 = ALUOut, 1 = memory data register
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  output  2  to ALU control
- PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite  output  1  unconditional PC write
- Branch  output  1  conditional PC write qualifier
- PCEn  output  1  PC enable, equal to PCWrite OR (Branch AND Zero)
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  4  current state, for debug and verification

## Operation
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- States use a 4-bit encoding:
  - FETCH=0
  - DECODE=1
  - MEMADR=2
  - MEMRD=3
  - MEMWB=4
  - MEMWR=5
  - RTYPEEX=6
  - RTYPEWB=7
  - BEQEX=8
  - ADDIEX=9
  - ADDIWB=10
  - JEX=11
  - Codes 12–15 are unused and go to FETCH on the next edge.
- Outputs are decoded from the current state, plus mem_ready where noted. Any output not listed for a state is 0.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWR: IorD=1, MemWrite=1, held until mem_ready.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JEX: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1; otherwise it stays in FETCH.
  - DECODE goes by Op: lw or sw → MEMADR; R-type → RTYPEEX; beq → BEQEX; addi → ADDIEX; j → JEX.
  - DECODE with any other opcode goes to FETCH and pulses illegal_op=1 in that DECODE cycle.
  - MEMADR goes to MEMRD for lw, MEMWR for sw.
  - MEMRD goes to MEMWB when mem_ready=1; otherwise it stays.
  - MEMWR goes to FETCH when mem_ready=1; otherwise it stays.
  - RTYPEEX → RTYPEWB; ADDIEX → ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX all go to FETCH.
- Op is sampled only in DECODE and MEMADR. Zero is used only in BEQEX.

## Timing
- Reset: with rst_n=0 at a rising edge, state becomes FETCH.
- While rst_n=0, these are forced to 0 combinationally regardless of state: IRWrite, PCWrite, PCEn, MemWrite, RegWrite, Branch, illegal_op.
- While rst_n=0, all selects and ALUOp show their FETCH values.
- Reset asserted mid-instruction abandons the instruction. No register or memory write occurs in the cycle where rst_n=0.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake: mem_ready is qualified only in FETCH, MEMRD and MEMWR, and is ignored in every other state.
- IorD and MemWrite stay stable for the whole time mem_ready is low.
- PCEn is combinational in the same cycle. It is 1 in BEQEX only when Zero=1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with mem_ready=1 → state=0, all strobes 0. Release → IRWrite=PCWrite=PCEn=1 in the first cycle.
- lw (Op=100011), mem_ready=1 → states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. ALUOp=00 in states 0–2.
- R-type (Op=000000) → states 0,1,6,7,0. ALUOp=10 in state 6. RegDst=1 and RegWrite=1 in state 7.
- beq (Op=000100), run twice:
  - Zero=1 → in state 8, PCEn=1, PCSrc=01, ALUOp=01.
  - Zero=0 → in state 8, PCEn=0.
- Stalls: sw with mem_ready=0 for 3 cycles in MEMWR → state 5 held 4 cycles with MemWrite=1 and IorD=1, then FETCH. FETCH with mem_ready=0 → IRWrite=PCWrite=0 and state stays 0.
- Op=111111 → DECODE pulses illegal_op for 1 cycle, then FETCH. rst_n=0 during state 7 → RegWrite=0 and state=0 on the next edge.
